// File: rtl/i2c_wb_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_wb_sequencer: Wishbone master that turns byte-level I2C requests     |
// | into the iicmb CSR/DPR/CMDR command sequence.   Revision: 1.0            |
// +--------------------------------------------------------------------------+
module i2c_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int BUS_ID         = 0,
  parameter int LEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_rnw_i,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]      req_len_i,
  input  logic [WB_DATA_WIDTH-1:0]  wr_data_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  output logic [WB_DATA_WIDTH-1:0]  rd_data_o,
  output logic                      rd_valid_o,
  output logic                      done_o,
  output logic [2:0]                status_o,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMO_MAX  = '1;
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);

  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

  localparam logic [WB_DATA_WIDTH-1:0] CSR_EN    = WB_DATA_WIDTH'(8'hC0);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_WRITE = WB_DATA_WIDTH'(8'h01);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_RDACK = WB_DATA_WIDTH'(8'h02);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_RDNAK = WB_DATA_WIDTH'(8'h03);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_START = WB_DATA_WIDTH'(8'h04);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_STOP  = WB_DATA_WIDTH'(8'h05);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_SETBS = WB_DATA_WIDTH'(8'h06);

  localparam logic [2:0] ST_OK = 3'd0, ST_NAK = 3'd1, ST_AL = 3'd2, ST_ERR = 3'd3, ST_TMO = 3'd4;

  typedef enum logic [3:0] {
    S_INIT_CSR, S_INIT_DPR, S_IDLE, S_ADDR_DPR, S_WR_WAIT, S_WR_DPR, S_RD_CMD,
    S_RD_DPR, S_STOP, S_CMD_WR, S_WAIT_IRQ, S_CMD_RD, S_DONE
  } state_t;

  state_t state_q, state_d, ret_q, ret_d;
  logic [WB_DATA_WIDTH-1:0]  cmd_q, cmd_d, wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      rnw_q, rnw_d, reinit_q, reinit_d, rd_valid_q, rd_valid_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [2:0]                pend_q, pend_d, status_q, status_d;
  logic                      cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0]  adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0]  dat_q, dat_d;

  logic                      acc_req, acc_we, acc_done;
  logic [WB_ADDR_WIDTH-1:0]  acc_adr;
  logic [WB_DATA_WIDTH-1:0]  acc_dat;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_INIT_CSR;
      ret_q      <= S_IDLE;
      cmd_q      <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
      reinit_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      pend_q     <= ST_OK;
      status_q   <= ST_OK;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      addr_q     <= addr_d;
      rnw_q      <= rnw_d;
      reinit_q   <= reinit_d;
      rd_valid_q <= rd_valid_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      pend_q     <= pend_d;
      status_q   <= status_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    addr_d     = addr_q;
    rnw_d      = rnw_q;
    reinit_d   = reinit_q;
    rd_valid_d = 1'b0;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
    status_d   = status_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    acc_req    = 1'b0;
    acc_we     = 1'b0;
    acc_adr    = '0;
    acc_dat    = '0;
    acc_done   = 1'b0;

    // Access-bearing states describe their bus cycle; the shared engine below runs it.
    case (state_q)
      S_INIT_CSR: begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_CSR;  acc_dat = CSR_EN; end
      S_INIT_DPR: begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_DPR;  acc_dat = WB_DATA_WIDTH'(BUS_ID); end
      S_ADDR_DPR: begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_DPR;  acc_dat = WB_DATA_WIDTH'({addr_q, rnw_q}); end
      S_WR_DPR:   begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_DPR;  acc_dat = wdata_q; end
      S_CMD_WR:   begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_CMDR; acc_dat = cmd_q; end
      S_RD_DPR:   begin acc_req = 1'b1; acc_adr = A_DPR;  end
      S_CMD_RD:   begin acc_req = 1'b1; acc_adr = A_CMDR; end
      default:    ;
    endcase

    // Returning to idle on ack leaves cyc_q low for a cycle, giving the mandatory gap.
    if (acc_req) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = acc_we;
        adr_d = acc_adr;
        dat_d = acc_dat;
      end else if (ack_i) begin
        cyc_d    = 1'b0;
        stb_d    = 1'b0;
        we_d     = 1'b0;
        adr_d    = '0;
        dat_d    = '0;
        acc_done = 1'b1;
      end
    end

    case (state_q)
      S_INIT_CSR: if (acc_done) state_d = S_INIT_DPR;
      S_INIT_DPR: if (acc_done) begin
        cmd_d = CMD_SETBS; ret_d = S_IDLE; state_d = S_CMD_WR;
      end
      S_IDLE: if (req_valid_i) begin
        addr_d  = req_addr_i;
        rnw_d   = req_rnw_i;
        cnt_d   = req_len_i;
        pend_d  = ST_OK;
        cmd_d   = CMD_START;
        ret_d   = S_ADDR_DPR;
        state_d = S_CMD_WR;
      end
      S_ADDR_DPR: if (acc_done) begin
        cmd_d   = CMD_WRITE;
        ret_d   = (cnt_q == '0) ? S_STOP : (rnw_q ? S_RD_CMD : S_WR_WAIT);
        state_d = S_CMD_WR;
      end
      S_WR_WAIT: if (wr_valid_i) begin
        wdata_d = wr_data_i;
        state_d = S_WR_DPR;
      end
      S_WR_DPR: if (acc_done) begin
        cmd_d   = CMD_WRITE;
        ret_d   = (cnt_q == CNT_ONE) ? S_STOP : S_WR_WAIT;
        cnt_d   = cnt_q - CNT_ONE;
        state_d = S_CMD_WR;
      end
      S_RD_CMD: begin
        cmd_d   = (cnt_q == CNT_ONE) ? CMD_RDNAK : CMD_RDACK;
        ret_d   = S_RD_DPR;
        state_d = S_CMD_WR;
      end
      S_RD_DPR: if (acc_done) begin
        rd_data_d  = dat_i;
        rd_valid_d = 1'b1;
        cnt_d      = cnt_q - CNT_ONE;
        state_d    = (cnt_q == CNT_ONE) ? S_STOP : S_RD_CMD;
      end
      S_STOP: begin
        cmd_d = CMD_STOP; ret_d = S_DONE; state_d = S_CMD_WR;
      end
      S_CMD_WR: if (acc_done) begin
        tmo_d   = '0;
        state_d = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = S_CMD_RD;
        end else if (tmo_q >= TMO_LAST) begin
          pend_d   = ST_TMO;
          reinit_d = 1'b1;
          state_d  = S_DONE;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_CMD_RD: if (acc_done) begin
        // Response priority: arbitration lost, then error, then NAK.
        if (dat_i[5]) begin
          pend_d = ST_AL;  state_d = S_DONE;
        end else if (dat_i[4]) begin
          pend_d = ST_ERR; state_d = S_DONE;
        end else if (dat_i[6] && cmd_q == CMD_WRITE) begin
          pend_d = ST_NAK; state_d = S_STOP;
        end else begin
          state_d = ret_q;
        end
      end
      S_DONE: begin
        reinit_d = 1'b0;
        state_d  = reinit_q ? S_INIT_CSR : S_IDLE;
      end
      default: state_d = S_INIT_CSR;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) status_d = pend_d;
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign wr_ready_o  = (state_q == S_WR_WAIT);
  assign done_o      = (state_q == S_DONE);
  assign status_o    = status_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_wb_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_wb_sequencer: iicmb register model plus queued expectations.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_wb_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_rnw = 1'b0, wr_valid = 1'b0;
  logic [6:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic [7:0] wr_data = '0;
  logic       req_ready, wr_ready, rd_valid, done, cyc, stb, we, ack, irq;
  logic [7:0] rd_data, dat_o, dat_in;
  logic [2:0] status;
  logic [1:0] adr;

  always #5 clk = ~clk;

  i2c_wb_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rnw_i(req_rnw),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .done_o(done), .status_o(status),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
    .dat_i(dat_in), .ack_i(ack), .irq_i(irq)
  );

  int         tests = 0, fails = 0, cmdr_reads = 0, irq_cnt = 0;
  logic [15:0] exp_wb[$];
  logic [7:0]  exp_rd[$];
  logic [2:0]  exp_st[$];
  logic [7:0]  cmdr_resp[$];
  logic [7:0]  dpr_data[$];
  bit          hold_irq = 1'b0, wr_rdy_seen = 1'b0, prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [1:0] a, input logic [7:0] d);
    exp_wb.push_back({6'b0, a, d});
  endtask

  task automatic push_init();
    push_wr(2'd0, 8'hC0); push_wr(2'd1, 8'h00); push_wr(2'd2, 8'h06);
  endtask

  // iicmb register model: one-cycle ack, irq three cycles after a CMDR write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0; irq <= 1'b0; irq_cnt <= 0; dat_in <= '0;
    end else begin
      ack <= cyc && stb && !ack;
      if (cyc && stb && !ack && !we) begin
        if (adr == 2'd2) begin
          if (cmdr_resp.size() != 0) dat_in <= cmdr_resp.pop_front();
          else dat_in <= 8'h80;
        end else if (adr == 2'd1) begin
          if (dpr_data.size() != 0) dat_in <= dpr_data.pop_front();
          else dat_in <= 8'hEE;
        end
      end
      if (irq_cnt != 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) irq <= 1'b1;
      end
      if (cyc && stb && ack && adr == 2'd2) begin
        if (we && !hold_irq) irq_cnt <= 3;
        if (!we) irq <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack = 1'b0;
    end else begin
      if (prev_ack) check("wb_idle_gap", cyc, 0);
      prev_ack = cyc && ack;
      if (cyc && stb && ack) begin
        if (we) begin
          if (exp_wb.size() == 0) begin
            tests++; fails++;
            $display("FAIL wb_write: unexpected write adr %0d dat 0x%0h", adr, dat_o);
          end else check("wb_write", {6'b0, adr, dat_o}, exp_wb.pop_front());
        end else if (adr == 2'd2) cmdr_reads++;
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_byte: unexpected byte 0x%0h", rd_data);
        end else check("rd_byte", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        if (exp_st.size() == 0) begin
          tests++; fails++;
          $display("FAIL status: unexpected done with status %0d", status);
        end else check("status", status, exp_st.pop_front());
      end
      if (wr_ready) wr_rdy_seen = 1'b1;
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    check(name, req_ready, 1);
  endtask

  task automatic send_req(input logic rnw, input logic [6:0] a, input logic [3:0] len);
    wait_ready("req_ready");
    req_valid = 1'b1; req_rnw = rnw; req_addr = a; req_len = len;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!wr_ready && n < 500) begin @(negedge clk); n++; end
    check("wr_ready", wr_ready, 1);
    wr_valid = 1'b1; wr_data = d;
    @(posedge clk); #1 wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 1000);
    check(name, done, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {cyc, stb, we, req_ready, wr_ready, rd_valid, done}, 0);
    check("reset_bus", {adr, dat_o}, 0);
    check("reset_status", status, 0);

    // Init sequence, then ready.
    push_init();
    rst_n = 1'b1;
    wait_ready("init_ready");
    check("init_cmdr_reads", cmdr_reads, 1);
    check("init_drained", exp_wb.size(), 0);

    // Two-byte write to 0x22.
    push_wr(2, 8'h04); push_wr(1, 8'h44); push_wr(2, 8'h01);
    push_wr(1, 8'h78); push_wr(2, 8'h01); push_wr(1, 8'h9A); push_wr(2, 8'h01);
    push_wr(2, 8'h05); exp_st.push_back(3'd0);
    send_req(1'b0, 7'h22, 4'd2);
    send_byte(8'h78); send_byte(8'h9A);
    wait_done("write_done", n);

    // Three-byte read from 0x22.
    dpr_data.push_back(8'h11); dpr_data.push_back(8'h22); dpr_data.push_back(8'h33);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    push_wr(2, 8'h04); push_wr(1, 8'h45); push_wr(2, 8'h01);
    push_wr(2, 8'h02); push_wr(2, 8'h02); push_wr(2, 8'h03); push_wr(2, 8'h05);
    exp_st.push_back(3'd0);
    send_req(1'b1, 7'h22, 4'd3);
    wait_done("read_done", n);
    check("read_bytes_left", exp_rd.size(), 0);

    // Address-only probe.
    push_wr(2, 8'h04); push_wr(1, 8'h45); push_wr(2, 8'h01); push_wr(2, 8'h05);
    exp_st.push_back(3'd0);
    send_req(1'b1, 7'h22, 4'd0);
    wait_done("probe_done", n);

    // Address NAK: no data, STOP, status NAK.
    cmdr_resp.push_back(8'h80); cmdr_resp.push_back(8'h40);
    push_wr(2, 8'h04); push_wr(1, 8'h20); push_wr(2, 8'h01); push_wr(2, 8'h05);
    exp_st.push_back(3'd1);
    wr_rdy_seen = 1'b0;
    send_req(1'b0, 7'h10, 4'd2);
    wait_done("nak_done", n);
    check("nak_no_wr_ready", wr_rdy_seen, 0);

    // Arbitration lost on START: no STOP, ready the following cycle.
    cmdr_resp.push_back(8'hA0);
    push_wr(2, 8'h04); exp_st.push_back(3'd2);
    send_req(1'b0, 7'h22, 4'd1);
    wait_done("al_done", n);
    check("al_ready_at_done", req_ready, 0);
    @(negedge clk);
    check("al_ready_next", req_ready, 1);
    check("al_status_held", status, 2);

    // Timeout waiting for irq, then full re-init.
    hold_irq = 1'b1;
    push_wr(2, 8'h04); exp_st.push_back(3'd4); push_init();
    send_req(1'b0, 7'h22, 4'd1);
    wait_done("tmo_done", n);
    hold_irq = 1'b0;
    check("tmo_window", (n >= 100 && n <= 108), 1);
    wait_ready("tmo_reinit_ready");
    check("tmo_reinit_drained", exp_wb.size(), 0);

    // Reset in the middle of a data-byte DPR write.
    push_wr(2, 8'h04); push_wr(1, 8'h44); push_wr(2, 8'h01);
    send_req(1'b0, 7'h22, 4'd2);
    send_byte(8'h55);
    n = 0;
    @(negedge clk);
    while (!cyc && n < 50) begin @(negedge clk); n++; end
    check("rst_cyc_before", {cyc, adr}, {1'b1, 2'd1});
    rst_n = 1'b0;
    #1;
    check("rst_cyc_async_drop", {cyc, stb, we}, 0);
    check("rst_pre_drained", exp_wb.size(), 0);
    repeat (3) @(negedge clk);
    check("rst_held_idle", {req_ready, done, status}, 0);
    push_init();
    rst_n = 1'b1;
    wait_ready("rst_reinit_ready");
    check("rst_reinit_drained", exp_wb.size(), 0);

    repeat (5) @(negedge clk);
    check("final_rd_queue", exp_rd.size(), 0);
    check("final_status_queue", exp_st.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
